// File: rtl/fpdiv32.sv
// fpdiv32: iterative IEEE-754 single-precision divider, R = A / B.
// A radix-2 restoring divider produces one quotient bit per clock. Every
// operation, special operands included, takes a fixed 26 cycles from ACT
// to RDY. Denormal inputs are flushed to zero and the result is truncated.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for ACT; captures operands, tag, sign and special flags
// DIV   | 25 restoring iterations, one quotient bit per clock
// PACK  | normalize, apply range and special overrides, strobe RDY
module fpdiv32 (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ACT,
    input  logic        TAGi,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        BUSY,
    output logic        RDY,
    output logic        TAGo,
    output logic [31:0] R
);

    typedef enum logic [1:0] {IDLE, DIV, PACK} state_t;

    state_t             state;
    logic [4:0]         cnt;
    logic [24:0]        rem;
    logic [24:0]        q;
    logic [23:0]        mb;
    logic signed [9:0]  exp_r;
    logic               sign_r;
    logic               tag_r;
    logic               sp_nan;
    logic               sp_inf;
    logic               sp_zero;

    logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    assign a_zero = (A[30:23] == 8'h00);
    assign a_inf  = (A[30:23] == 8'hff) && (A[22:0] == 23'd0);
    assign a_nan  = (A[30:23] == 8'hff) && (A[22:0] != 23'd0);
    assign b_zero = (B[30:23] == 8'h00);
    assign b_inf  = (B[30:23] == 8'hff) && (B[22:0] == 23'd0);
    assign b_nan  = (B[30:23] == 8'hff) && (B[22:0] != 23'd0);

    // Partial remainder is always below 2*mB, so after a successful trial
    // subtraction the difference fits in 24 bits and the MSB can be dropped.
    logic        rem_ge;
    logic [23:0] rem_sub;
    assign rem_ge  = (rem >= {1'b0, mb});
    assign rem_sub = rem[23:0] - mb;

    logic signed [9:0] exp_n;
    logic [22:0]       frac_n;
    logic [31:0]       pack_r;

    // Normalize the quotient and select the packed result with overrides.
    always_comb begin
        exp_n  = q[24] ? exp_r : (exp_r - 10'sd1);
        frac_n = q[24] ? q[23:1] : q[22:0];
        pack_r = 32'd0;
        if (sp_nan)
            pack_r = {sign_r, 8'hff, 23'h7fffff};
        else if (sp_inf)
            pack_r = {sign_r, 8'hff, 23'd0};
        else if (sp_zero)
            pack_r = 32'd0;
        else if (exp_n >= 10'sd255)
            pack_r = {sign_r, 8'hff, 23'd0};
        else if (exp_n <= 10'sd0)
            pack_r = 32'd0;
        else
            pack_r = {sign_r, exp_n[7:0], frac_n};
    end

    // Sequencer and datapath: capture, iterate, pack with registered outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= IDLE;
            cnt     <= 5'd0;
            rem     <= 25'd0;
            q       <= 25'd0;
            mb      <= 24'd0;
            exp_r   <= 10'sd0;
            sign_r  <= 1'b0;
            tag_r   <= 1'b0;
            sp_nan  <= 1'b0;
            sp_inf  <= 1'b0;
            sp_zero <= 1'b0;
            BUSY    <= 1'b0;
            RDY     <= 1'b0;
            TAGo    <= 1'b0;
            R       <= 32'd0;
        end else begin
            RDY <= 1'b0;
            case (state)
                IDLE: begin
                    if (ACT) begin
                        rem     <= {2'b01, A[22:0]};
                        q       <= 25'd0;
                        mb      <= {1'b1, B[22:0]};
                        exp_r   <= $signed({2'b00, A[30:23]}) - $signed({2'b00, B[30:23]}) + 10'sd127;
                        sign_r  <= A[31] ^ B[31];
                        tag_r   <= TAGi;
                        sp_nan  <= a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
                        sp_inf  <= a_inf | b_zero;
                        sp_zero <= a_zero | b_inf;
                        cnt     <= 5'd0;
                        BUSY    <= 1'b1;
                        state   <= DIV;
                    end
                end
                DIV: begin
                    q <= {q[23:0], rem_ge};
                    if (rem_ge)
                        rem <= {rem_sub, 1'b0};
                    else
                        rem <= {rem[23:0], 1'b0};
                    if (cnt == 5'd24)
                        state <= PACK;
                    else
                        cnt <= cnt + 5'd1;
                end
                PACK: begin
                    R     <= pack_r;
                    TAGo  <= tag_r;
                    RDY   <= 1'b1;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpdiv32.sv
// Testbench for fpdiv32: directed cases plus random operands, scoreboard
// with expected result, tag and completion cycle; a monitor checks each RDY.
module tb_fpdiv32;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        ACT = 1'b0;
    logic        TAGi = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        BUSY, RDY, TAGo;
    logic [31:0] R;

    fpdiv32 dut (
        .CLK  (CLK),
        .RESET(RESET),
        .ACT  (ACT),
        .TAGi (TAGi),
        .A    (A),
        .B    (B),
        .BUSY (BUSY),
        .RDY  (RDY),
        .TAGo (TAGo),
        .R    (R)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        tag;
        logic [31:0] r;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   busy_run = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: quotient from integer division of the full mantissas.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        int          ea, eb, e;
        logic [22:0] fa, fb;
        logic        s, az, ai, an, bz, bi, bn;
        longint      qq;
        logic [22:0] frac;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        fa = a[22:0];        fb = b[22:0];
        s  = a[31] ^ b[31];
        az = (ea == 0); ai = (ea == 255) && (fa == 0); an = (ea == 255) && (fa != 0);
        bz = (eb == 0); bi = (eb == 255) && (fb == 0); bn = (eb == 255) && (fb != 0);
        if (an || bn || (az && bz) || (ai && bi)) return {s, 8'hff, 23'h7fffff};
        if (ai || bz) return {s, 8'hff, 23'd0};
        if (az || bi) return 32'd0;
        qq = ((longint'(fa) + 64'h800000) * 64'h1000000) / (longint'(fb) + 64'h800000);
        e  = ea - eb + 127;
        if (qq >= 64'h1000000) begin
            frac = 23'(qq / 2);
        end else begin
            frac = 23'(qq);
            e    = e - 1;
        end
        if (e >= 255) return {s, 8'hff, 23'd0};
        if (e <= 0) return 32'd0;
        return {s, 8'(e), frac};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        int          k;
        v = $urandom();
        k = int'($urandom_range(0, 11));
        case (k)
            0: v[30:23] = 8'h00;
            1: begin v[30:23] = 8'hff; v[22:0] = 23'd0; end
            2: begin v[30:23] = 8'hff; if (v[22:0] == 23'd0) v[0] = 1'b1; end
            3: v[30:23] = 8'(1 + $urandom_range(0, 3));
            4: v[30:23] = 8'(250 + $urandom_range(0, 4));
            default: v[30:23] = 8'(64 + $urandom_range(0, 127));
        endcase
        return v;
    endfunction

    // Monitor: every RDY must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (RDY) begin
            chk("busy_len", 32'(busy_run), 32'd26);
            if (sb.size() == 0) begin
                chk("spurious_rdy", {31'd0, RDY}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", R, e.r);
                chk("tag", {31'd0, TAGo}, {31'd0, e.tag});
                chk("latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (BUSY) busy_run = busy_run + 1;
        else      busy_run = 0;
    end

    // Waits (bounded) for BUSY low at a falling edge, then presents one ACT.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic tag,
                         input logic [31:0] expv);
        int   n;
        exp_t e;
        n = 0;
        while (BUSY && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (BUSY) begin
            $display("FAIL busy_timeout: BUSY stuck high after %0d cycles", n);
            n_tests++;
            n_fail++;
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $fatal(1, "busy timeout");
        end
        A = a; B = b; TAGi = tag; ACT = 1'b1;
        e.tag = tag; e.r = expv; e.cyc = cyc + 27;
        sb.push_back(e);
        @(negedge CLK);
        ACT = 1'b0;
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rt;
        int          n;

        repeat (3) @(negedge CLK);
        chk("reset_busy", {31'd0, BUSY}, 32'd0);
        chk("reset_rdy", {31'd0, RDY}, 32'd0);
        chk("reset_r", R, 32'd0);
        RESET = 1'b1;
        @(negedge CLK);

        issue(32'h40C00000, 32'h40000000, 1'b1, 32'h40400000);
        issue(32'h3F800000, 32'h40400000, 1'b0, 32'h3EAAAAAA);
        issue(32'hC0C00000, 32'h40000000, 1'b1, 32'hC0400000);
        issue(32'h3F800000, 32'h00000000, 1'b0, 32'h7F800000);
        issue(32'hBF800000, 32'h00000000, 1'b1, 32'hFF800000);
        issue(32'h00000000, 32'h00000000, 1'b0, 32'h7FFFFFFF);
        issue(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FFFFFFF);
        issue(32'h00000000, 32'h40000000, 1'b0, 32'h00000000);
        issue(32'h7FC00001, 32'h3F800000, 1'b1, 32'h7FFFFFFF);
        issue(32'h7F000000, 32'h3E800000, 1'b0, 32'h7F800000);
        issue(32'h00800000, 32'h40000000, 1'b1, 32'h00000000);

        // A second ACT while busy must be ignored.
        issue(32'h40C00000, 32'h40000000, 1'b1, 32'h40400000);
        repeat (3) @(negedge CLK);
        A = 32'h41000000; B = 32'h3F800000; TAGi = 1'b0; ACT = 1'b1;
        @(negedge CLK);
        ACT = 1'b0;

        // Reset mid-operation discards the in-flight result.
        issue(32'h40400000, 32'h3F800000, 1'b1, 32'h40400000);
        repeat (8) @(negedge CLK);
        @(posedge CLK);
        #1 RESET = 1'b0;
        #1;
        chk("midreset_busy", {31'd0, BUSY}, 32'd0);
        chk("midreset_rdy", {31'd0, RDY}, 32'd0);
        chk("midreset_tag", {31'd0, TAGo}, 32'd0);
        chk("midreset_r", R, 32'd0);
        void'(sb.pop_back());
        @(negedge CLK);
        RESET = 1'b1;
        repeat (40) @(negedge CLK);
        issue(32'h41200000, 32'h40A00000, 1'b0, 32'h40000000);

        for (int i = 0; i < 150; i++) begin
            ra = rand_op();
            rb = rand_op();
            rt = 1'($urandom());
            issue(ra, rb, rt, ref_div(ra, rb));
        end

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        repeat (5) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
